// File: rtl/adc_capture_pkg.sv
// Shared types, default parameters and width helpers for the ADC frame capture engine.
package adc_capture_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FRAME_LEN  = 512;
  localparam int DEF_SETTLE_CYC = 7;
  localparam int DEF_NUM_CH     = 1;
  localparam int DEF_END_CYC    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    END     = 2'd3
  } state_t;

  // Ceiling log2, never less than 1 so single-value fields still get a bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int ch_width(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

  function automatic int idx_width(input int frame_len);
    return clog2_min1(frame_len);
  endfunction

endpackage

// File: rtl/adc_out_slot.sv
// Single-entry valid/ready output register; drops a capture when the held beat
// has not been taken and records that in a sticky overflow flag.
module adc_out_slot
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = 1,
  parameter int IDX_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cap,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_last,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_last,
  output logic              o_overflow
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_ch;
  logic [IDX_W-1:0]  r_idx;
  logic              r_last;
  logic              r_overflow;
  logic              w_free;
  logic              w_load;
  logic              w_drop;

  assign w_free = !r_valid || i_ready;
  assign w_load = i_cap && w_free && !i_flush;
  assign w_drop = i_cap && !w_free && !i_flush;

  // Flush wins over a new load so an abort never leaves a beat behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_ch   <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= i_data;
      r_ch   <= i_ch;
      r_idx  <= i_idx;
      r_last <= i_last;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_ch       = r_ch;
  assign o_idx      = r_idx;
  assign o_last     = r_last;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/adc_frame_capture.sv
// ADC frame capture engine: start, settle, capture FRAME_LEN tagged samples,
// hold in END, then stop or loop for continuous capture.
module adc_frame_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int END_CYC    = DEF_END_CYC
) (
  input  logic                            clk_adc_i,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            cont_i,
  input  logic [DATA_W-1:0]               adc_data_i,
  input  logic                            ready_i,
  output logic                            valid_o,
  output logic [DATA_W-1:0]               data_o,
  output logic [ch_width(NUM_CH)-1:0]     ch_o,
  output logic [idx_width(FRAME_LEN)-1:0] idx_o,
  output logic                            last_o,
  output logic                            busy_o,
  output logic                            frame_done_o,
  output logic                            overflow_o
);

  localparam int CH_W     = ch_width(NUM_CH);
  localparam int IDX_W    = idx_width(FRAME_LEN);
  localparam int WAIT_MAX = (SETTLE_CYC > END_CYC) ? SETTLE_CYC : END_CYC;
  localparam int WAIT_W   = clog2_min1(WAIT_MAX + 1);
  localparam int SET_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int END_LAST = (END_CYC > 0) ? END_CYC - 1 : 0;
  localparam int IDX_LAST = FRAME_LEN - 1;
  localparam int CH_LAST  = NUM_CH - 1;

  if (FRAME_LEN < 2 || (FRAME_LEN % NUM_CH) != 0) begin : g_bad_frame_len
    $error("adc_frame_capture: FRAME_LEN must be >= 2 and a multiple of NUM_CH");
  end

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [CH_W-1:0]   r_ch;
  logic              r_frame_done;
  logic              r_busy;
  logic              w_idx_last;
  logic              w_cap;
  logic              w_clr_ovf;

  assign w_idx_last = (r_idx == IDX_W'(IDX_LAST));

  // State register.
  always_ff @(posedge clk_adc_i or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; abort overrides every other input.
  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) w_next = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
          else         w_next = IDLE;
        end
        SETTLE: begin
          if (r_wait_cnt == WAIT_W'(SET_LAST)) w_next = CAPTURE;
          else                                 w_next = SETTLE;
        end
        CAPTURE: begin
          if (w_idx_last) begin
            if (END_CYC == 0) w_next = cont_i ? CAPTURE : IDLE;
            else              w_next = END;
          end else begin
            w_next = CAPTURE;
          end
        end
        END: begin
          if (r_wait_cnt == WAIT_W'(END_LAST)) w_next = cont_i ? CAPTURE : IDLE;
          else                                 w_next = END;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Per-state control strobes.
  always_comb begin
    w_cap     = 1'b0;
    w_clr_ovf = 1'b0;
    case (r_state)
      IDLE:    w_clr_ovf = start_i && !abort_i;
      CAPTURE: w_cap     = !abort_i;
      default: begin
        w_cap     = 1'b0;
        w_clr_ovf = 1'b0;
      end
    endcase
  end

  // One counter serves both SETTLE and END; it restarts on every state change.
  always_ff @(posedge clk_adc_i or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETTLE || r_state == END) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Index and channel advance on every capture cycle, kept or dropped.
  always_ff @(posedge clk_adc_i or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_ch  <= '0;
    end else if (w_cap) begin
      r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      r_ch  <= (w_idx_last || r_ch == CH_W'(CH_LAST)) ? '0 : r_ch + CH_W'(1);
    end else begin
      r_idx <= '0;
      r_ch  <= '0;
    end
  end

  always_ff @(posedge clk_adc_i or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_cap && w_idx_last;
      r_busy       <= (w_next != IDLE);
    end
  end

  adc_out_slot #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .IDX_W  (IDX_W)
  ) u_slot (
    .i_clk      (clk_adc_i),
    .i_rst      (reset),
    .i_cap      (w_cap),
    .i_flush    (abort_i),
    .i_clr_ovf  (w_clr_ovf),
    .i_ready    (ready_i),
    .i_data     (adc_data_i),
    .i_ch       (r_ch),
    .i_idx      (r_idx),
    .i_last     (w_idx_last),
    .o_valid    (valid_o),
    .o_data     (data_o),
    .o_ch       (ch_o),
    .o_idx      (idx_o),
    .o_last     (last_o),
    .o_overflow (overflow_o)
  );

  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: default build driven through a scoreboard,
// plus a 4-channel, 8-sample, zero-settle build for channel tags and async reset.
module tb_adc_frame_capture;

  typedef struct packed {
    logic [15:0] d;
    logic [0:0]  c;
    logic [8:0]  i;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst0, rst1;
  logic        d0_start, d0_abort, d0_cont, d0_ready;
  logic [15:0] d0_data;
  logic        o0_valid, o0_last, o0_busy, o0_frame_done, o0_overflow;
  logic [15:0] o0_data;
  logic [0:0]  o0_ch;
  logic [8:0]  o0_idx;
  logic        d1_start, d1_abort, d1_cont, d1_ready;
  logic [11:0] d1_data, d1_val;
  logic        o1_valid, o1_last, o1_busy, o1_frame_done, o1_overflow;
  logic [11:0] o1_data;
  logic [1:0]  o1_ch;
  logic [2:0]  o1_idx;

  int    vec, miss, fd_cnt, beats;
  logic  m_valid, prev_valid, prev_rdy;
  logic [15:0] ramp;
  beat_t held, exp_b, b;
  beat_t sb[$];

  adc_frame_capture #(.DATA_W(16), .FRAME_LEN(512), .SETTLE_CYC(7), .NUM_CH(1), .END_CYC(2)) dut0 (
    .clk_adc_i(clk), .reset(rst0), .start_i(d0_start), .abort_i(d0_abort), .cont_i(d0_cont),
    .adc_data_i(d0_data), .ready_i(d0_ready), .valid_o(o0_valid), .data_o(o0_data), .ch_o(o0_ch),
    .idx_o(o0_idx), .last_o(o0_last), .busy_o(o0_busy), .frame_done_o(o0_frame_done),
    .overflow_o(o0_overflow));

  adc_frame_capture #(.DATA_W(12), .FRAME_LEN(8), .SETTLE_CYC(0), .NUM_CH(4), .END_CYC(2)) dut1 (
    .clk_adc_i(clk), .reset(rst1), .start_i(d1_start), .abort_i(d1_abort), .cont_i(d1_cont),
    .adc_data_i(d1_data), .ready_i(d1_ready), .valid_o(o1_valid), .data_o(o1_data), .ch_o(o1_ch),
    .idx_o(o1_idx), .last_o(o1_last), .busy_o(o1_busy), .frame_done_o(o1_frame_done),
    .overflow_o(o1_overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of dut0: drive, predict, then check what the DUT presents.
  task automatic step(input bit cap, input int idx, input bit rdy, input bit st, input bit ab);
    d0_ready = rdy;
    d0_start = st;
    d0_abort = ab;
    d0_data  = ramp;
    ramp     = ramp + 16'd1;
    if (ab) begin
      m_valid = 1'b0;
    end else if (cap) begin
      if (!m_valid || rdy) begin
        b.d = d0_data;
        b.c = 1'b0;
        b.i = idx[8:0];
        b.l = (idx == 511);
        sb.push_back(b);
      end
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    prev_rdy = rdy;
    @(posedge clk);
    #1;
    d0_start = 1'b0;
    d0_abort = 1'b0;
    chk("valid", o0_valid, m_valid);
    if (o0_valid && (!prev_valid || prev_rdy)) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", o0_idx, 9'h1ff);
      end else begin
        exp_b = sb.pop_front();
        chk("beat", {o0_data, o0_ch, o0_idx, o0_last}, exp_b);
        held = exp_b;
        beats++;
      end
    end else if (o0_valid) begin
      chk("held_stable", {o0_data, o0_ch, o0_idx, o0_last}, held);
    end
    if (o0_frame_done) begin
      fd_cnt++;
      chk("fd_with_last", {o0_valid, o0_last}, 2'b11);
    end
    prev_valid = o0_valid;
  endtask

  task automatic start_and_settle();
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    vec = 0; miss = 0; fd_cnt = 0; beats = 0;
    m_valid = 1'b0; prev_valid = 1'b0; prev_rdy = 1'b1; ramp = 16'h1000; held = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    d0_start = 1'b0; d0_abort = 1'b0; d0_cont = 1'b0; d0_ready = 1'b1; d0_data = 16'h0;
    d1_start = 1'b0; d1_abort = 1'b0; d1_cont = 1'b0; d1_ready = 1'b1; d1_data = 12'h0; d1_val = 12'h0;
    #1;
    chk("rst_outputs0", {o0_valid, o0_data, o0_ch, o0_idx, o0_last, o0_busy, o0_frame_done, o0_overflow}, 64'h0);
    chk("rst_outputs1", {o1_valid, o1_data, o1_ch, o1_idx, o1_last, o1_busy, o1_frame_done, o1_overflow}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_rst", o0_busy, 1'b0);

    // Single shot, ready held high.
    fd_cnt = 0; beats = 0;
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("busy_after_start", o0_busy, 1'b1);
    for (int i = 1; i <= 7; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("no_valid_in_settle", o0_valid, 1'b0);
    for (int i = 0; i < 512; i++) begin
      step(1'b1, i, 1'b1, 1'b0, 1'b0);
      if (i == 0) chk("first_valid_edge8", o0_valid, 1'b1);
    end
    chk("frame_done_at_last", {o0_frame_done, o0_last, o0_idx}, {2'b11, 9'd511});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("busy_in_end", o0_busy, 1'b1);
    chk("fd_one_cycle", o0_frame_done, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("idle_after_end", o0_busy, 1'b0);
    chk("fd_count_single", fd_cnt, 1);
    chk("beats_single", beats, 512);
    chk("sb_empty_single", sb.size(), 0);

    // Backpressure: ready low while idx 100..102 are sampled.
    fd_cnt = 0; beats = 0;
    start_and_settle();
    for (int i = 0; i < 512; i++) begin
      step(1'b1, i, !(i >= 100 && i <= 102), 1'b0, 1'b0);
      if (i == 99)  chk("no_ovf_yet", o0_overflow, 1'b0);
      if (i == 102) chk("ovf_set", o0_overflow, 1'b1);
      if (i == 103) chk("idx_jump", o0_idx, 9'd103);
    end
    chk("frame_done_ovf", o0_frame_done, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("fd_count_ovf", fd_cnt, 1);
    chk("beats_ovf", beats, 509);
    chk("ovf_sticky", o0_overflow, 1'b1);

    // Continuous: two frames, END gap only, no re-settle.
    fd_cnt = 0; beats = 0;
    d0_cont = 1'b1;
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("start_clears_ovf", o0_overflow, 1'b0);
    for (int i = 1; i <= 7; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("cont_busy_end1", o0_busy, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("cont_busy_end2", o0_busy, 1'b1);
    for (int i = 0; i < 512; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
    d0_cont = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("cont_stop_idle", o0_busy, 1'b0);
    chk("fd_count_cont", fd_cnt, 2);
    chk("beats_cont", beats, 1024);

    // Abort behaviour.
    fd_cnt = 0;
    step(1'b0, 0, 1'b1, 1'b1, 1'b1);
    chk("abort_start_stays_idle", o0_busy, 1'b0);
    start_and_settle();
    for (int i = 0; i < 99; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
    step(1'b1, 99, 1'b0, 1'b0, 1'b0);
    chk("ovf_before_abort", o0_overflow, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("abort_idle", {o0_busy, o0_valid, o0_frame_done}, 3'b000);
    chk("abort_keeps_ovf", o0_overflow, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("restart_clears_ovf", {o0_busy, o0_overflow}, 2'b10);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("abort_settle_idle", o0_busy, 1'b0);
    chk("fd_count_abort", fd_cnt, 0);
    chk("sb_empty_abort", sb.size(), 0);

    // dut1: 4 channels, 8 samples, zero settle.
    d1_start = 1'b1;
    @(posedge clk);
    #1;
    d1_start = 1'b0;
    chk("d1_busy", {o1_busy, o1_valid}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      d1_val  = 12'h100 + 12'(k * 7);
      d1_data = d1_val;
      @(posedge clk);
      #1;
      chk("d1_beat", {o1_valid, o1_data, o1_ch, o1_idx, o1_last},
          {1'b1, d1_val, 2'(k % 4), 3'(k), (k == 7)});
    end
    chk("d1_frame_done", o1_frame_done, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("d1_idle", o1_busy, 1'b0);

    // dut1: async reset mid-capture with a pending beat and overflow set.
    d1_ready = 1'b0;
    d1_start = 1'b1;
    @(posedge clk);
    #1;
    d1_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d1_data = 12'hA50 + 12'(k);
      @(posedge clk);
      #1;
    end
    chk("d1_pending", {o1_valid, o1_overflow, o1_data}, {2'b11, 12'hA50});
    #2;
    rst1 = 1'b1;
    #1;
    chk("d1_async_rst", {o1_valid, o1_data, o1_ch, o1_idx, o1_last, o1_busy, o1_frame_done, o1_overflow}, 64'h0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    d1_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("d1_idle_after_rst", {o1_busy, o1_valid}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
